rx_loopback_checker: RTL



---
 rtl/rx_loopback_checker_pkg.sv | 14 +
 rtl/rx_bit_aligner.sv | 61 ++++++
 rtl/rx_loopback_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rx_loopback_checker_pkg.sv
// Shared definitions for the RX loopback checker.
// Holds the FSM state encoding and the data width shared with counter_datagen.
package rx_loopback_checker_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OFF_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/rx_bit_aligner.sv
// Bit rotation stage: keeps the previous valid word and extracts the word
// starting at bit_offset from {prev_word, data_in}.
// Ports:
//   clk, rst        - clock, async active-high reset
//   data_in         - raw deserializer word, bit 7 earliest
//   data_valid      - data_in qualifier
//   bit_offset      - rotation to apply
//   aligned_c       - combinational aligned word (for the checker FSM)
//   aligned_data    - registered aligned word
//   aligned_valid   - registered qualifier for aligned_data
module rx_bit_aligner
  import rx_loopback_checker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [OFF_W-1:0]  bit_offset,
  output logic [DATA_W-1:0] aligned_c,
  output logic [DATA_W-1:0] aligned_data,
  output logic              aligned_valid
);

  logic [DATA_W-1:0]   prev_word_q, prev_word_d;
  logic [DATA_W-1:0]   aligned_data_q, aligned_data_d;
  logic                aligned_valid_q, aligned_valid_d;
  logic [2*DATA_W-1:0] shifted;

  // Rotation mux: cat[7+off:off]
  always_comb begin
    shifted   = {prev_word_q, data_in} >> bit_offset;
    aligned_c = shifted[DATA_W-1:0];
  end

  // Next-state for history and output registers; invalid words change nothing
  always_comb begin
    prev_word_d     = prev_word_q;
    aligned_data_d  = aligned_data_q;
    aligned_valid_d = data_valid;
    if (data_valid) begin
      prev_word_d    = data_in;
      aligned_data_d = aligned_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_word_q     <= '0;
      aligned_data_q  <= '0;
      aligned_valid_q <= 1'b0;
    end else begin
      prev_word_q     <= prev_word_d;
      aligned_data_q  <= aligned_data_d;
      aligned_valid_q <= aligned_valid_d;
    end
  end

  assign aligned_data  = aligned_data_q;
  assign aligned_valid = aligned_valid_q;

endmodule

// File: rtl/rx_loopback_checker.sv
// Loopback checker: searches the eight rotations of the RX word stream for an
// incrementing 8-bit counter, locks, then counts mismatches against the
// free-running expected value.
// Ports:
//   clk, rst        - clock, async active-high reset
//   enable          - run the checker (0 forces IDLE)
//   clr_err         - synchronous clear of err_count
//   data_in         - raw deserializer word, data_valid qualifies it
//   aligned_data    - rotated word, aligned_valid qualifies it
//   bit_offset      - current / locked rotation
//   locked          - high while locked
//   err_flag        - one-cycle pulse per mismatched word while locked
//   err_count       - saturating mismatch count
module rx_loopback_checker
  import rx_loopback_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] aligned_data,
  output logic              aligned_valid,
  output logic [OFF_W-1:0]  bit_offset,
  output logic              locked,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT);
  localparam int unsigned ERUN_W = $clog2(ERR_LIMIT + 1);

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [DATA_W-1:0]  ref_q, ref_d;
  logic [DATA_W-1:0]  exp_q, exp_d;
  logic               has_ref_q, has_ref_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [ERUN_W-1:0]  err_run_q, err_run_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               err_flag_q, err_flag_d;
  logic               locked_q, locked_d;
  logic [DATA_W-1:0]  aligned_c;
  logic [ERUN_W-1:0]  err_run_inc;

  rx_bit_aligner u_aligner (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .bit_offset   (off_q),
    .aligned_c    (aligned_c),
    .aligned_data (aligned_data),
    .aligned_valid(aligned_valid)
  );

  // Search / lock / check FSM and counters
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    ref_d       = ref_q;
    exp_d       = exp_q;
    has_ref_d   = has_ref_q;
    run_d       = run_q;
    err_run_d   = err_run_q;
    err_count_d = err_count_q;
    err_flag_d  = 1'b0;
    err_run_inc = err_run_q + ERUN_W'(1);

    if (!enable) begin
      state_d   = ST_IDLE;
      has_ref_d = 1'b0;
      run_d     = '0;
      err_run_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (data_valid) begin
            if (!has_ref_q) begin
              ref_d     = aligned_c;
              has_ref_d = 1'b1;
            end else if (aligned_c == ref_q + DATA_W'(1)) begin
              ref_d = aligned_c;
              if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
                state_d = ST_LOCKED;
                exp_d   = aligned_c + DATA_W'(1);
                run_d   = '0;
              end else begin
                run_d = run_q + RUN_W'(1);
              end
            end else begin
              off_d     = off_q + OFF_W'(1);
              run_d     = '0;
              has_ref_d = 1'b0;
            end
          end
        end
        ST_LOCKED: begin
          if (data_valid) begin
            // Expected free-runs so one bad word costs exactly one error
            exp_d = exp_q + DATA_W'(1);
            if (aligned_c == exp_q) begin
              err_run_d = '0;
            end else begin
              err_flag_d = 1'b1;
              err_run_d  = err_run_inc;
              if (err_run_inc == ERUN_W'(ERR_LIMIT)) begin
                state_d   = ST_SEARCH;
                run_d     = '0;
                err_run_d = '0;
                has_ref_d = 1'b0;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Clear wins over hold, but a simultaneous mismatch still counts
    if (clr_err) begin
      err_count_d = err_flag_d ? ERR_W'(1) : '0;
    end else if (err_flag_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      ref_q       <= '0;
      exp_q       <= '0;
      has_ref_q   <= 1'b0;
      run_q       <= '0;
      err_run_q   <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      ref_q       <= ref_d;
      exp_q       <= exp_d;
      has_ref_q   <= has_ref_d;
      run_q       <= run_d;
      err_run_q   <= err_run_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
      locked_q    <= locked_d;
    end
  end

  assign bit_offset = off_q;
  assign locked     = locked_q;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;

endmodule
